pong_game_ctrl: RTL



---
 rtl/pong_pkg.sv | 47 ++++
 rtl/frame_tick_gen.sv | 26 ++
 rtl/pong_game_ctrl.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
// Shared types, default geometry and helpers for the Pong game controller.
package pong_pkg;

  typedef enum logic [1:0] {
    StServe,
    StPlay,
    StPause,
    StOver
  } game_state_e;

  localparam int unsigned H_ACTIVE_DEF     = 640;
  localparam int unsigned V_ACTIVE_DEF     = 480;
  localparam int unsigned BALL_SIZE_DEF    = 8;
  localparam int unsigned PADDLE_H_DEF     = 64;
  localparam int unsigned PADDLE_W_DEF     = 8;
  localparam int unsigned PADDLE_LX_DEF    = 16;
  localparam int unsigned PADDLE_RX_DEF    = 616;
  localparam int unsigned PADDLE_STEP_DEF  = 4;
  localparam int unsigned BALL_STEP_DEF    = 2;
  localparam int unsigned WIN_SCORE_DEF    = 5;
  localparam int unsigned PAUSE_FRAMES_DEF = 60;

  function automatic logic [9:0] centre_pos(input int unsigned span, input int unsigned size);
    return 10'((span - size) / 2);
  endfunction

  localparam logic [9:0] BALL_X0_DEF = centre_pos(H_ACTIVE_DEF, BALL_SIZE_DEF);
  localparam logic [9:0] BALL_Y0_DEF = centre_pos(V_ACTIVE_DEF, BALL_SIZE_DEF);
  localparam logic [9:0] PADDLE_Y0_DEF = centre_pos(V_ACTIVE_DEF, PADDLE_H_DEF);

  // One paddle step; opposing buttons cancel, result clamped to 0..y_max.
  function automatic logic [9:0] paddle_next(input logic [9:0] y, input logic up,
                                             input logic dn, input logic [10:0] step,
                                             input logic [10:0] y_max);
    logic [10:0] ye;
    logic [10:0] res;
    ye  = {1'b0, y};
    res = ye;
    if (up && !dn) begin
      res = (ye < step) ? 11'd0 : ye - step;
    end else if (dn && !up) begin
      res = (ye + step > y_max) ? y_max : ye + step;
    end
    return res[9:0];
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Synchronises the active-low vertical sync and emits a one-cycle tick on its falling edge.
module frame_tick_gen (
  input  logic iVGA_CLK,
  input  logic iRST_n,
  input  logic iVS,
  output logic frame_tick
);

  logic vs_meta_q, vs_sync_q, vs_prev_q;

  // Flops reset high to match idle sync so no spurious tick follows reset.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      vs_meta_q <= 1'b1;
      vs_sync_q <= 1'b1;
      vs_prev_q <= 1'b1;
    end else begin
      vs_meta_q <= iVS;
      vs_sync_q <= vs_meta_q;
      vs_prev_q <= vs_sync_q;
    end
  end

  assign frame_tick = vs_prev_q & ~vs_sync_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// Frame-sequenced Pong controller: ball, paddles, score and win state, advanced once per frame.
// Define PONG_AI_EN to have the right paddle track the ball instead of its buttons.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned H_ACTIVE     = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE     = V_ACTIVE_DEF,
  parameter int unsigned BALL_SIZE    = BALL_SIZE_DEF,
  parameter int unsigned PADDLE_H     = PADDLE_H_DEF,
  parameter int unsigned PADDLE_W     = PADDLE_W_DEF,
  parameter int unsigned PADDLE_LX    = PADDLE_LX_DEF,
  parameter int unsigned PADDLE_RX    = PADDLE_RX_DEF,
  parameter int unsigned PADDLE_STEP  = PADDLE_STEP_DEF,
  parameter int unsigned BALL_STEP    = BALL_STEP_DEF,
  parameter int unsigned WIN_SCORE    = WIN_SCORE_DEF,
  parameter int unsigned PAUSE_FRAMES = PAUSE_FRAMES_DEF
) (
  input  logic       iVGA_CLK,
  input  logic       iRST_n,
  input  logic       iVS,
  input  logic       iStart,
  input  logic       iL_up,
  input  logic       iL_dn,
  input  logic       iR_up,
  input  logic       iR_dn,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [9:0] paddleL_y,
  output logic [9:0] paddleR_y,
  output logic [2:0] scoreL,
  output logic [2:0] scoreR,
  output logic       game_over,
  output logic       left_win,
  output logic       right_win
);

  localparam logic [10:0] BallXMax  = 11'(H_ACTIVE - BALL_SIZE);
  localparam logic [10:0] BallYMax  = 11'(V_ACTIVE - BALL_SIZE);
  localparam logic [10:0] PadYMax   = 11'(V_ACTIVE - PADDLE_H);
  localparam logic [10:0] LeftFace  = 11'(PADDLE_LX + PADDLE_W);
  localparam logic [10:0] RightFace = 11'(PADDLE_RX - BALL_SIZE);
  localparam logic [10:0] BallStep  = 11'(BALL_STEP);
  localparam logic [10:0] PadStep   = 11'(PADDLE_STEP);
  localparam logic [10:0] BallSz    = 11'(BALL_SIZE);
  localparam logic [10:0] PadH      = 11'(PADDLE_H);
  localparam logic [9:0]  BallX0    = centre_pos(H_ACTIVE, BALL_SIZE);
  localparam logic [9:0]  BallY0    = centre_pos(V_ACTIVE, BALL_SIZE);
  localparam logic [9:0]  PadY0     = centre_pos(V_ACTIVE, PADDLE_H);
  localparam int unsigned CntW      = (PAUSE_FRAMES > 1) ? $clog2(PAUSE_FRAMES) : 1;
  localparam logic [CntW-1:0] PauseLast = CntW'(PAUSE_FRAMES - 1);
  localparam logic [2:0]  WinScore  = 3'(WIN_SCORE);

  logic tick;

  frame_tick_gen u_frame_tick (
    .iVGA_CLK  (iVGA_CLK),
    .iRST_n    (iRST_n),
    .iVS       (iVS),
    .frame_tick(tick)
  );

  game_state_e     state_q, state_d;
  logic [9:0]      bx_q, bx_d, by_q, by_d, pl_q, pl_d, pr_q, pr_d;
  logic [2:0]      sl_q, sl_d, sr_q, sr_d;
  logic            dx_q, dx_d, dy_q, dy_d;  // 1 = moving toward larger coordinate
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            win_r_q, win_r_d;

  logic [10:0] bx_ext, by_ext, pl_ext, pr_ext, vy, hx;
  logic        vdy, hdx, overlap_l, overlap_r, point_l, point_r;
  logic        r_up, r_dn;
  logic [2:0]  score_new;

  assign bx_ext = {1'b0, bx_q};
  assign by_ext = {1'b0, by_q};
  assign pl_ext = {1'b0, pl_q};
  assign pr_ext = {1'b0, pr_q};

`ifdef PONG_AI_EN
  logic [10:0] ball_c, pad_c;
  logic        unused_r_btn;
  assign unused_r_btn = iR_up ^ iR_dn;
  assign ball_c = by_ext + (BallSz >> 1);
  assign pad_c  = pr_ext + (PadH >> 1);
  assign r_dn   = ball_c > pad_c + PadStep;
  assign r_up   = ball_c + PadStep < pad_c;
`else
  assign r_up = iR_up;
  assign r_dn = iR_dn;
`endif

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q <= StServe;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      bx_q    <= BallX0;
      by_q    <= BallY0;
      pl_q    <= PadY0;
      pr_q    <= PadY0;
      sl_q    <= '0;
      sr_q    <= '0;
      dx_q    <= 1'b1;
      dy_q    <= 1'b1;
      cnt_q   <= '0;
      win_r_q <= 1'b0;
    end else begin
      bx_q    <= bx_d;
      by_q    <= by_d;
      pl_q    <= pl_d;
      pr_q    <= pr_d;
      sl_q    <= sl_d;
      sr_q    <= sr_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      cnt_q   <= cnt_d;
      win_r_q <= win_r_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bx_d      = bx_q;
    by_d      = by_q;
    pl_d      = pl_q;
    pr_d      = pr_q;
    sl_d      = sl_q;
    sr_d      = sr_q;
    dx_d      = dx_q;
    dy_d      = dy_q;
    cnt_d     = cnt_q;
    win_r_d   = win_r_q;
    score_new = '0;

    vy  = by_ext;
    vdy = dy_q;
    if (!dy_q) begin
      if (by_ext < BallStep) begin
        vy  = '0;
        vdy = 1'b1;
      end else begin
        vy = by_ext - BallStep;
      end
    end else if (by_ext + BallStep > BallYMax) begin
      vy  = BallYMax;
      vdy = 1'b0;
    end else begin
      vy = by_ext + BallStep;
    end

    // Collisions use pre-tick ball and paddle positions.
    overlap_l = (by_ext + BallSz > pl_ext) && (by_ext < pl_ext + PadH);
    overlap_r = (by_ext + BallSz > pr_ext) && (by_ext < pr_ext + PadH);
    hx        = bx_ext;
    hdx       = dx_q;
    point_l   = 1'b0;
    point_r   = 1'b0;
    if (!dx_q) begin
      if (bx_ext <= LeftFace + BallStep && overlap_l) begin
        hx  = LeftFace;
        hdx = 1'b1;
      end else if (bx_ext < BallStep) begin
        point_r = 1'b1;
      end else begin
        hx = bx_ext - BallStep;
      end
    end else begin
      if (bx_ext + BallStep >= RightFace && overlap_r) begin
        hx  = RightFace;
        hdx = 1'b0;
      end else if (bx_ext + BallStep > BallXMax) begin
        point_l = 1'b1;
      end else begin
        hx = bx_ext + BallStep;
      end
    end

    if (tick) begin
      if (state_q != StOver) begin
        pl_d = paddle_next(pl_q, iL_up, iL_dn, PadStep, PadYMax);
        pr_d = paddle_next(pr_q, r_up, r_dn, PadStep, PadYMax);
      end
      unique case (state_q)
        StServe: begin
          if (iStart) state_d = StPlay;
        end
        StPlay: begin
          if (point_l || point_r) begin
            score_new = point_l ? sl_q + 3'd1 : sr_q + 3'd1;
            if (point_l) sl_d = score_new;
            else         sr_d = score_new;
            if (score_new == WinScore) begin
              state_d = StOver;
              win_r_d = point_r;
            end else begin
              state_d = StPause;
              bx_d    = BallX0;
              by_d    = BallY0;
              cnt_d   = '0;
              dx_d    = point_l;  // serve toward the player who lost the point
              dy_d    = vdy;
            end
          end else begin
            bx_d = hx[9:0];
            by_d = vy[9:0];
            dx_d = hdx;
            dy_d = vdy;
          end
        end
        StPause: begin
          if (cnt_q == PauseLast) state_d = StPlay;
          else                    cnt_d   = cnt_q + 1'b1;
        end
        StOver: begin
          if (iStart) begin
            state_d = StServe;
            sl_d    = '0;
            sr_d    = '0;
            bx_d    = BallX0;
            by_d    = BallY0;
          end
        end
      endcase
    end
  end

  always_comb begin
    ball_x    = bx_q;
    ball_y    = by_q;
    paddleL_y = pl_q;
    paddleR_y = pr_q;
    scoreL    = sl_q;
    scoreR    = sr_q;
    game_over = (state_q == StOver);
    left_win  = game_over & ~win_r_q;
    right_win = game_over & win_r_q;
  end

endmodule
